// File: rtl/toy_ldq_mem_tracker.sv
// LDQ memory-load issue register plus in-order in-flight tracker with live/stale epoch accounting.
// Optional protocol checking is enabled by defining TOY_LDQ_MEM_TRACKER_ERR_CHK_EN.
module toy_ldq_mem_tracker #(
    parameter int unsigned DEPTH         = 8,
    parameter int unsigned ADDR_WIDTH    = 32,
    parameter int unsigned DATA_WIDTH    = 64,
    parameter int unsigned REG_IDX_WIDTH = 6,
    parameter int unsigned BRANCH_WIDTH  = 3,
    localparam int unsigned CW           = $clog2(DEPTH) + 1,
    localparam int unsigned PW           = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ld_req_vld,
    output logic                     ld_req_rdy,
    input  logic [ADDR_WIDTH-1:0]    ld_req_addr,
    input  logic [REG_IDX_WIDTH-1:0] ld_req_rd_idx,
    input  logic [BRANCH_WIDTH-1:0]  req_branch_id_nxt,
    input  logic                     cancel_edge_en,
    output logic                     mem_req_vld,
    input  logic                     mem_req_rdy,
    output logic [ADDR_WIDTH-1:0]    mem_req_addr,
    output logic [BRANCH_WIDTH-1:0]  mem_req_branch_id,
    input  logic                     mem_ack_vld,
    input  logic [DATA_WIDTH-1:0]    mem_ack_data,
    input  logic                     branch_ack_vld,
    output logic                     wb_vld,
    output logic [REG_IDX_WIDTH-1:0] wb_rd_idx,
    output logic [DATA_WIDTH-1:0]    wb_data,
    output logic [CW-1:0]            outstanding_cnt,
    output logic                     idle,
    output logic                     err
);

    localparam logic [CW:0]   DepthW = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] DepthC = CW'(DEPTH);

    logic                     vld_q, vld_d;
    logic [ADDR_WIDTH-1:0]    addr_q;
    logic [BRANCH_WIDTH-1:0]  bid_q;
    logic [REG_IDX_WIDTH-1:0] rd_q;
    logic [CW-1:0]            live_q, live_d, stale_q, stale_d;
    logic [PW-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [REG_IDX_WIDTH-1:0] fifo_q [DEPTH];
    logic                     wb_vld_q, idle_q;
    logic [REG_IDX_WIDTH-1:0] wb_rd_idx_q;
    logic [DATA_WIDTH-1:0]    wb_data_q;

    logic        accept, handshake, push, live_pop, stale_ack;
    logic [CW:0] credit_sum, stale_sum;

    assign outstanding_cnt   = live_q + stale_q;
    assign credit_sum        = {1'b0, outstanding_cnt} + (CW + 1)'(vld_q);
    assign ld_req_rdy        = (~vld_q | mem_req_rdy) & (credit_sum < DepthW) & ~cancel_edge_en;
    assign accept            = ld_req_vld & ld_req_rdy;
    assign handshake         = vld_q & mem_req_rdy;
    assign push              = handshake & ~cancel_edge_en;
    // Acks against an empty class are ignored so the counters never underflow.
    assign live_pop          = mem_ack_vld & branch_ack_vld & (live_q != '0);
    assign stale_ack         = mem_ack_vld & ~branch_ack_vld & (stale_q != '0);

    assign mem_req_vld       = vld_q;
    assign mem_req_addr      = addr_q;
    assign mem_req_branch_id = bid_q;
    assign wb_vld            = wb_vld_q;
    assign wb_rd_idx         = wb_rd_idx_q;
    assign wb_data           = wb_data_q;
    assign idle              = idle_q;

    always_comb begin
        vld_d = vld_q;
        if (accept) begin
            vld_d = 1'b1;
        end else if (handshake || cancel_edge_en) begin
            vld_d = 1'b0;
        end

        live_d   = live_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (live_pop) rd_ptr_d = rd_ptr_q + PW'(1);
        if (cancel_edge_en) begin
            live_d   = '0;
            rd_ptr_d = wr_ptr_q;
        end else if (push && !live_pop && live_q != DepthC) begin
            live_d = live_q + CW'(1);
        end else if (live_pop && !push) begin
            live_d = live_q - CW'(1);
        end

        // On cancel everything still live (minus this cycle's pop) becomes stale.
        stale_sum = {1'b0, stale_q};
        if (stale_ack) stale_sum = stale_sum - (CW + 1)'(1);
        if (cancel_edge_en) begin
            stale_sum = stale_sum + {1'b0, live_q} - (CW + 1)'(live_pop) + (CW + 1)'(handshake);
        end
        if (stale_sum > DepthW) stale_sum = DepthW;
        stale_d = stale_sum[CW-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q       <= 1'b0;
            addr_q      <= '0;
            bid_q       <= '0;
            rd_q        <= '0;
            live_q      <= '0;
            stale_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            wb_vld_q    <= 1'b0;
            wb_rd_idx_q <= '0;
            wb_data_q   <= '0;
            idle_q      <= 1'b0;
        end else begin
            vld_q    <= vld_d;
            live_q   <= live_d;
            stale_q  <= stale_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            wb_vld_q <= live_pop;
            idle_q   <= ~vld_d & ((live_d + stale_d) == '0);
            if (accept) begin
                addr_q <= ld_req_addr;
                bid_q  <= req_branch_id_nxt;
                rd_q   <= ld_req_rd_idx;
            end
            if (live_pop) begin
                wb_rd_idx_q <= fifo_q[rd_ptr_q];
                wb_data_q   <= mem_ack_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= rd_q;
    end

`ifdef TOY_LDQ_MEM_TRACKER_ERR_CHK_EN
    logic err_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if ((mem_ack_vld && outstanding_cnt == '0) || (branch_ack_vld && !mem_ack_vld) ||
                     (push && outstanding_cnt == DepthC)) begin
            err_q <= 1'b1;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_toy_ldq_mem_tracker.sv
// Directed bench for toy_ldq_mem_tracker: queue-based reference model checked every cycle,
// plus literal expectations at the scenario milestones.
module tb_toy_ldq_mem_tracker;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ld_req_vld = 1'b0;
    logic        ld_req_rdy;
    logic [31:0] ld_req_addr = '0;
    logic [5:0]  ld_req_rd_idx = '0;
    logic [2:0]  req_branch_id_nxt = '0;
    logic        cancel_edge_en = 1'b0;
    logic        mem_req_vld;
    logic        mem_req_rdy = 1'b0;
    logic [31:0] mem_req_addr;
    logic [2:0]  mem_req_branch_id;
    logic        mem_ack_vld = 1'b0;
    logic [63:0] mem_ack_data = '0;
    logic        branch_ack_vld = 1'b0;
    logic        wb_vld;
    logic [5:0]  wb_rd_idx;
    logic [63:0] wb_data;
    logic [3:0]  outstanding_cnt;
    logic        idle;
    logic        err;

    toy_ldq_mem_tracker dut (
        .clk(clk), .rst_n(rst_n),
        .ld_req_vld(ld_req_vld), .ld_req_rdy(ld_req_rdy), .ld_req_addr(ld_req_addr),
        .ld_req_rd_idx(ld_req_rd_idx), .req_branch_id_nxt(req_branch_id_nxt),
        .cancel_edge_en(cancel_edge_en),
        .mem_req_vld(mem_req_vld), .mem_req_rdy(mem_req_rdy), .mem_req_addr(mem_req_addr),
        .mem_req_branch_id(mem_req_branch_id),
        .mem_ack_vld(mem_ack_vld), .mem_ack_data(mem_ack_data), .branch_ack_vld(branch_ack_vld),
        .wb_vld(wb_vld), .wb_rd_idx(wb_rd_idx), .wb_data(wb_data),
        .outstanding_cnt(outstanding_cnt), .idle(idle), .err(err)
    );

    always #5 clk = ~clk;

`ifdef TOY_LDQ_MEM_TRACKER_ERR_CHK_EN
    localparam bit ErrOn = 1'b1;
`else
    localparam bit ErrOn = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a pending-request slot, a queue of live destinations and a stale count.
    bit          m_vld = 0;
    logic [31:0] m_addr = '0;
    logic [2:0]  m_bid = '0;
    logic [5:0]  m_rd = '0;
    logic [5:0]  m_live[$];
    int          m_stale = 0;
    bit          m_wb = 0;
    logic [5:0]  m_wb_rd = '0;
    logic [63:0] m_wb_data = '0;
    bit          m_err = 0;
    bit          m_idle = 0;

    function automatic bit model_rdy();
        return (!m_vld || mem_req_rdy) && (m_live.size() + m_stale + int'(m_vld) < DEPTH)
               && !cancel_edge_en;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_vld = 0; m_live.delete(); m_stale = 0; m_wb = 0; m_err = 0; m_idle = 0;
        end else begin
            bit acc, hs, lpop, sack;
            int total;
            acc   = ld_req_vld && model_rdy();
            hs    = m_vld && mem_req_rdy;
            total = m_live.size() + m_stale;
            lpop  = mem_ack_vld && branch_ack_vld && m_live.size() > 0;
            sack  = mem_ack_vld && !branch_ack_vld && m_stale > 0;
            if (ErrOn && ((mem_ack_vld && total == 0) || (branch_ack_vld && !mem_ack_vld)))
                m_err = 1;
            m_wb = lpop;
            if (lpop) begin
                m_wb_rd   = m_live.pop_front();
                m_wb_data = mem_ack_data;
            end
            if (sack) m_stale--;
            if (cancel_edge_en) begin
                m_stale += m_live.size() + int'(hs);
                m_live.delete();
            end else if (hs) begin
                m_live.push_back(m_rd);
            end
            if (acc) begin
                m_vld = 1; m_addr = ld_req_addr; m_bid = req_branch_id_nxt; m_rd = ld_req_rd_idx;
            end else if (hs || cancel_edge_en) begin
                m_vld = 0;
            end
            m_idle = !m_vld && (m_live.size() + m_stale == 0);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("ld_req_rdy", 64'(ld_req_rdy), 64'(model_rdy()));
            chk("mem_req_vld", 64'(mem_req_vld), 64'(m_vld));
            if (m_vld) begin
                chk("mem_req_addr", 64'(mem_req_addr), 64'(m_addr));
                chk("mem_req_branch_id", 64'(mem_req_branch_id), 64'(m_bid));
            end
            chk("wb_vld", 64'(wb_vld), 64'(m_wb));
            if (m_wb) begin
                chk("wb_rd_idx", 64'(wb_rd_idx), 64'(m_wb_rd));
                chk("wb_data", wb_data, m_wb_data);
            end
            chk("outstanding_cnt", 64'(outstanding_cnt), 64'(m_live.size() + m_stale));
            chk("idle", 64'(idle), 64'(m_idle));
            chk("err", 64'(err), 64'(m_err));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [5:0] rd);
        ld_req_vld        = 1'b1;
        ld_req_rd_idx     = rd;
        ld_req_addr       = 32'h1000 + 32'(rd);
        req_branch_id_nxt = rd[2:0];
        step();
        ld_req_vld = 1'b0;
    endtask

    task automatic ack(input bit live, input logic [63:0] d);
        mem_ack_vld    = 1'b1;
        branch_ack_vld = live;
        mem_ack_data   = d;
        step();
        mem_ack_vld    = 1'b0;
        branch_ack_vld = 1'b0;
    endtask

    initial begin
        repeat (3) step();
        chk("rst mem_req_vld", 64'(mem_req_vld), 64'd0);
        chk("rst wb_vld", 64'(wb_vld), 64'd0);
        chk("rst outstanding", 64'(outstanding_cnt), 64'd0);
        chk("rst err", 64'(err), 64'd0);
        rst_n = 1'b1;
        step();
        chk("idle after reset", 64'(idle), 64'd1);

        // 1: three live loads written back in order
        mem_req_rdy = 1'b1;
        for (int i = 1; i <= 3; i++) load(6'(i));
        step();
        chk("t1 outstanding", 64'(outstanding_cnt), 64'd3);
        for (int i = 0; i < 3; i++) begin
            ack(1'b1, 64'hD0 + 64'(i));
            chk("t1 wb_vld", 64'(wb_vld), 64'd1);
            chk("t1 wb_rd_idx", 64'(wb_rd_idx), 64'(i + 1));
            chk("t1 wb_data", wb_data, 64'hD0 + 64'(i));
        end
        step();
        chk("t1 wb_vld low", 64'(wb_vld), 64'd0);
        chk("t1 idle", 64'(idle), 64'd1);

        // 2: fill all credits, one ack frees a credit
        for (int i = 0; i < 8; i++) load(6'(8 + i));
        step();
        chk("t2 full cnt", 64'(outstanding_cnt), 64'd8);
        chk("t2 full rdy", 64'(ld_req_rdy), 64'd0);
        ack(1'b1, 64'hA0);
        chk("t2 rdy after ack", 64'(ld_req_rdy), 64'd1);
        chk("t2 cnt after ack", 64'(outstanding_cnt), 64'd7);
        for (int i = 1; i < 8; i++) ack(1'b1, 64'hA0 + 64'(i));
        step();
        chk("t2 drained", 64'(outstanding_cnt), 64'd0);

        // 3: cancel four in-flight loads, then four stale acks
        for (int i = 0; i < 4; i++) load(6'(16 + i));
        step();
        cancel_edge_en = 1'b1;
        step();
        cancel_edge_en = 1'b0;
        chk("t3 stale cnt", 64'(outstanding_cnt), 64'd4);
        for (int i = 0; i < 4; i++) begin
            ack(1'b0, 64'hB0);
            chk("t3 no wb", 64'(wb_vld), 64'd0);
        end
        chk("t3 drained", 64'(outstanding_cnt), 64'd0);

        // 4: cancel a stalled request, then cancel during a handshake
        mem_req_rdy = 1'b0;
        load(6'd20);
        step();
        chk("t4 held", 64'(mem_req_vld), 64'd1);
        cancel_edge_en = 1'b1;
        step();
        cancel_edge_en = 1'b0;
        chk("t4 dropped", 64'(mem_req_vld), 64'd0);
        chk("t4 no stale", 64'(outstanding_cnt), 64'd0);
        load(6'd21);
        mem_req_rdy    = 1'b1;
        cancel_edge_en = 1'b1;
        step();
        cancel_edge_en = 1'b0;
        chk("t4 hs stale", 64'(outstanding_cnt), 64'd1);
        chk("t4 vld low", 64'(mem_req_vld), 64'd0);
        ack(1'b0, 64'hC0);
        chk("t4 drained", 64'(outstanding_cnt), 64'd0);

        // 5: live ack in the cancel cycle with two in flight
        load(6'd30);
        load(6'd31);
        step();
        cancel_edge_en = 1'b1;
        ack(1'b1, 64'hE5);
        cancel_edge_en = 1'b0;
        chk("t5 wb_vld", 64'(wb_vld), 64'd1);
        chk("t5 wb_rd_idx", 64'(wb_rd_idx), 64'd30);
        chk("t5 wb_data", wb_data, 64'hE5);
        chk("t5 stale", 64'(outstanding_cnt), 64'd1);
        ack(1'b0, 64'hE6);
        chk("t5 no wb", 64'(wb_vld), 64'd0);
        chk("t5 drained", 64'(outstanding_cnt), 64'd0);

        // 6: ack while idle
        ack(1'b1, 64'hF0);
        chk("t6 err", 64'(err), 64'(ErrOn));
        chk("t6 no wb", 64'(wb_vld), 64'd0);
        chk("t6 cnt", 64'(outstanding_cnt), 64'd0);
        repeat (3) step();
        chk("t6 err sticky", 64'(err), 64'(ErrOn));
        chk("t6 idle", 64'(idle), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
